// File: rtl/rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8
//
// Eight-channel round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner returns `done` or until it has been held
// for TIMEOUT cycles, whichever comes first. Every release is followed by
// one idle cycle before the next grant can be issued.
//
// Parameters:
//   TIMEOUT      maximum grant hold length in cycles (legal 2..255)
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   req[7:0]     request lines, bit i = channel i
//   done         owner releases its grant (only looked at while granting)
//   grant[7:0]   registered grant, one-hot while granting, else zero
//   grant_valid  registered, high exactly when grant is non-zero
//   timeout      registered single-cycle pulse on a forced release
//
// Handshake: a channel is served when its req bit is sampled high in IDLE
// and it wins the scan; from then on req is ignored, and the grant ends on
// the first edge that samples done=1 or at the hold limit. There is no
// back-pressure on the arbiter outputs.
//
// The FSM state is held in the `state` register (IDLE/GRANT) for checkers.
// ---------------------------------------------------------------------------
module rr_arbiter_8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [2:0]    ptr;
    logic [2:0]    ptr_n;
    logic [2:0]    owner;
    logic [2:0]    owner_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [7:0]    grant_n;
    logic          grant_valid_n;
    logic          timeout_n;

    logic          found;
    logic [2:0]    sel;

    // Scan ptr, ptr+1, ... ptr+7 (3-bit wrap) and take the first request.
    always_comb begin : pick
        found = 1'b0;
        sel   = ptr;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[3'(ptr + 3'(i))]) begin
                found = 1'b1;
                sel   = 3'(ptr + 3'(i));
            end
        end
    end

    always_comb begin : next_state
        state_n       = state;
        ptr_n         = ptr;
        owner_n       = owner;
        cnt_n         = cnt;
        grant_n       = grant;
        grant_valid_n = grant_valid;
        timeout_n     = 1'b0;

        case (state)
            IDLE: begin
                grant_n       = 8'h00;
                grant_valid_n = 1'b0;
                if (found) begin
                    grant_n       = 8'h01 << sel;
                    grant_valid_n = 1'b1;
                    owner_n       = sel;
                    cnt_n         = '0;
                    state_n       = GRANT;
                end
            end
            GRANT: begin
                if (done || (cnt == CNT_LAST)) begin
                    grant_n       = 8'h00;
                    grant_valid_n = 1'b0;
                    ptr_n         = owner + 3'd1;
                    state_n       = IDLE;
                    // A done on the same edge as the limit is a normal release.
                    timeout_n     = !done;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n       = IDLE;
                grant_n       = 8'h00;
                grant_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            owner       <= 3'd0;
            cnt         <= '0;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            cnt         <= cnt_n;
            grant       <= grant_n;
            grant_valid <= grant_valid_n;
            timeout     <= timeout_n;
        end
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-channel round-robin arbiter. Samples eight request lines and issues a registered one-hot grant that holds until the owner signals completion or a hold timeout expires. It sits directly upstream of the 8-to-3 one-hot encoder: `grant` drives the encoder's 8-bit one-hot input, and `grant_valid` qualifies the encoded index. This is needed because an all-zero input also encodes to 3'b000.

## Interface
- `TIMEOUT`, 16: maximum number of cycles a grant may be held without `done`. Legal range 2..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req` input 8: request lines; bit i is the request from channel i.
- `done` input 1: the current owner releases its grant; sampled only while granting.
- `grant` output 8: registered grant; one-hot while granting, otherwise all zero.
- `grant_valid` output 1: registered; high exactly when `grant` is non-zero.
- `timeout` output 1: registered single-cycle pulse; the grant was force-released.

## Operation
- State machine with two states, IDLE and GRANT. Internal state:
  - `ptr[2:0]`: round-robin start index.
  - `cnt`: hold counter, width ceil(log2(TIMEOUT)).
- Reset (rst_n=0 at an edge):
  - state=IDLE, ptr=0, cnt=0.
  - grant=8'h00, grant_valid=0, timeout=0.
  - Reset overrides everything, including mid-grant.
- IDLE:
  - If req==0: stay in IDLE; outputs remain zero.
  - Otherwise select the first set bit of req, scanning indices ptr, ptr+1, …, ptr+7 (mod 8).
  - Register grant=(1<<sel) and grant_valid=1, clear cnt, and go to GRANT.
  - `done` is ignored in IDLE.
- GRANT:
  - grant is held constant; `req` is ignored, including the owner deasserting its own request.
  - done=1: grant=0, grant_valid=0, ptr=(sel+1) mod 8, go to IDLE.
  - done=0 and cnt==TIMEOUT-1: same release as for done, and timeout=1 for one cycle.
  - Otherwise cnt increments by 1.
- If done and the timeout condition occur at the same edge, the release counts as done, and timeout stays 0.
- ptr wraps from 7 to 0. ptr is unchanged while in IDLE with no requests.
- Invariants: grant is never multi-hot; grant_valid == (grant != 0); timeout is never high for two consecutive cycles.

## Timing
- Request-to-grant latency is 1 cycle: req sampled at edge k in IDLE gives grant visible after edge k.
- Release latency is 1 cycle: done sampled at edge k gives grant=0 after edge k.
- After every release there is one mandatory idle cycle. The next grant is issued at the earliest at edge k+1. Maximum throughput is one grant per 2 cycles when done is returned immediately.
- Hold length without done is exactly TIMEOUT cycles of grant_valid=1. The timeout pulse coincides with the first cycle of grant_valid=0.
- The downstream encoder output is combinational from `grant`, so the index is valid in the same cycles as grant_valid.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with req=8'hFF → grant=8'h00, grant_valid=0, timeout=0. After release, the first grant is 8'h01 (ptr=0).
- **Round-robin rotation:** req=8'hFF held, done=1 during every GRANT cycle → grants follow the sequence 01,02,04,…,80,01, each separated by one idle cycle. The encoder output follows 0..7 and then wraps to 0.
- **Sparse requests and wrap:** after channel 6 is served, req=8'b0010_0001 → grant=8'h01 (scan 7,0 wraps), then grant=8'h20.
- **Timeout:** TIMEOUT=16, req=8'h08, done held 0 → grant=8'h08 for exactly 16 cycles, then grant=0 with timeout=1 for one cycle. ptr=4, so a following req=8'h18 grants 8'h10.
- **Simultaneous done and timeout:** assert done in the 16th GRANT cycle → release occurs with timeout=0.
- **Mid-operation events:**
  - Owner drops req while granted → grant held until done.
  - rst_n=0 mid-grant → grant=0 at the next edge, and ptr returns to 0.
